// File: rtl/decomp_pkg.sv
// Shared types and defaults for the decompressor line sequencer.
package decomp_pkg;
  localparam int LINE_W          = 128;
  localparam int LINE_CNT_W_DFLT = 10;

  typedef enum logic [2:0] {IDLE, PRIME, RUN, STALL, RAW, DONE} seq_state_e;
endpackage

// File: rtl/line_skid_buf.sv
// Two-entry valid/ready line buffer with occupancy; a push while full with no pop is dropped and flagged.
module line_skid_buf
  import decomp_pkg::*;
#(
  parameter int W     = LINE_W,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         wr_vld_i,
  input  logic [W-1:0] wr_dat_i,
  output logic         wr_err_o,
  output logic         rd_vld_o,
  output logic [W-1:0] rd_dat_o,
  input  logic         rd_rdy_i,
  output logic [1:0]   occ_o,
  output logic         full_o
);
  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   occ_q, occ_d;
  logic         push, pop;

  always_comb begin
    full_o   = (occ_q == 2'(DEPTH));
    rd_vld_o = (occ_q != 2'd0);
    pop      = rd_vld_o && rd_rdy_i;
    // A pop in the same cycle frees the slot, so a full buffer can still take a write.
    push     = wr_vld_i && (!full_o || pop);
    wr_err_o = wr_vld_i && !push;
    occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
    occ_o    = occ_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/decomp_line_sequencer.sv
// Feeds one block of lines through the word decompressor (or bypasses it for raw blocks) into a skid buffer.
// DECOMP_SEQ_PERF_EN adds saturating stall/backpressure cycle counters.
module decomp_line_sequencer
  import decomp_pkg::*;
#(
  parameter int WIDTH_DATA_IN = LINE_W,
  parameter int LINE_CNT_W    = LINE_CNT_W_DFLT,
  parameter int SKID_DEPTH    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_start_comp,
  input  logic [LINE_CNT_W-1:0]    i_out_lines,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [WIDTH_DATA_IN-1:0] i_in_data,
  output logic                     o_dec_en,
  output logic                     o_dec_update,
  output logic [WIDTH_DATA_IN-1:0] o_dec_data,
  output logic                     o_comp_flag,
  input  logic                     i_dec_need,
  input  logic                     i_dec_valid,
  input  logic [WIDTH_DATA_IN-1:0] i_dec_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [WIDTH_DATA_IN-1:0] o_out_data,
  output logic                     o_out_last,
  output logic                     o_busy,
  output logic                     o_done
`ifdef DECOMP_SEQ_PERF_EN
  ,
  output logic [31:0]              o_stall_cycles,
  output logic [31:0]              o_bp_cycles
`endif
);
  localparam logic [LINE_CNT_W-1:0] CNT_ONE = 1;

  seq_state_e               state_q, state_d;
  logic                     err_q;
  logic [LINE_CNT_W-1:0]    lines_q, out_cnt_q, out_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [1:0]               occ;
  logic                     skid_full, skid_wr_vld, skid_wr_err;
  logic [WIDTH_DATA_IN-1:0] skid_wr_dat;
  logic                     comp_act, in_fire, pop, wr_room, bp, start_ok;

  always_comb begin
    state_d    = state_q;
    o_in_ready = 1'b0;
    o_dec_en   = 1'b0;
    comp_act   = 1'b0;
    // One slot stays free for a line already in flight from the decompressor.
    bp         = (occ != 2'd0) && !i_out_ready;
    wr_room    = (wr_cnt_q != lines_q);
    start_ok   = (state_q == IDLE) && i_start;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_out_lines == '0)  state_d = DONE;
          else if (i_start_comp)  state_d = PRIME;
          else                    state_d = RAW;
        end
      end
      PRIME: begin
        comp_act   = 1'b1;
        o_dec_en   = 1'b1;
        o_in_ready = !skid_full;
        if (i_in_valid && !skid_full) state_d = RUN;
      end
      RUN: begin
        comp_act   = 1'b1;
        o_dec_en   = !bp;
        o_in_ready = i_dec_need && !skid_full;
        if (i_dec_need && !i_in_valid) state_d = STALL;
      end
      STALL: begin
        comp_act   = 1'b1;
        o_in_ready = !skid_full;
        if (i_in_valid && !skid_full) state_d = RUN;
      end
      RAW:     o_in_ready = !skid_full && wr_room;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_fire      = i_in_valid && o_in_ready;
    pop          = o_out_valid && i_out_ready;
    o_out_last   = o_out_valid && (out_cnt_q == lines_q - CNT_ONE);
    if (pop && o_out_last && (state_q != IDLE) && (state_q != DONE)) state_d = DONE;

    skid_wr_vld  = comp_act ? (i_dec_valid && wr_room) : ((state_q == RAW) && in_fire);
    skid_wr_dat  = comp_act ? i_dec_data : i_in_data;
    o_dec_update = comp_act && in_fire;
    o_dec_data   = o_dec_update ? i_in_data : '0;
    o_comp_flag  = comp_act;
    o_busy       = (state_q != IDLE) || err_q;
    o_done       = (state_q == DONE);
    out_cnt_d    = out_cnt_q + (pop ? CNT_ONE : '0);
    wr_cnt_d     = wr_cnt_q + ((skid_wr_vld && !skid_wr_err) ? CNT_ONE : '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      lines_q   <= '0;
      out_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q || skid_wr_err;
      if (start_ok) begin
        lines_q   <= i_out_lines;
        out_cnt_q <= '0;
        wr_cnt_q  <= '0;
      end else begin
        out_cnt_q <= out_cnt_d;
        wr_cnt_q  <= wr_cnt_d;
      end
    end
  end

  line_skid_buf #(.W(WIDTH_DATA_IN), .DEPTH(SKID_DEPTH)) u_skid (
    .clk_i    (i_clk),
    .reset_i  (i_reset),
    .wr_vld_i (skid_wr_vld),
    .wr_dat_i (skid_wr_dat),
    .wr_err_o (skid_wr_err),
    .rd_vld_o (o_out_valid),
    .rd_dat_o (o_out_data),
    .rd_rdy_i (i_out_ready),
    .occ_o    (occ),
    .full_o   (skid_full)
  );

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset) !skid_wr_err);

`ifdef DECOMP_SEQ_PERF_EN
  logic [31:0] stall_cnt_q, bp_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || start_ok) begin
      stall_cnt_q <= '0;
      bp_cnt_q    <= '0;
    end else begin
      if ((state_q == STALL) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q != IDLE) && bp && (bp_cnt_q != '1)) bp_cnt_q <= bp_cnt_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cnt_q;
  assign o_bp_cycles    = bp_cnt_q;
`endif
endmodule

// File: tb/tb_decomp_line_sequencer.sv
// Self-checking bench for decomp_line_sequencer: cycle table for raw/empty blocks plus scripted compressed-block sequences.
module tb_decomp_line_sequencer;
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic         i_reset, i_start, i_start_comp, i_in_valid, o_in_ready;
  logic [9:0]   i_out_lines;
  logic [127:0] i_in_data, o_dec_data, i_dec_data, o_out_data;
  logic         o_dec_en, o_dec_update, o_comp_flag, i_dec_need, i_dec_valid;
  logic         o_out_valid, i_out_ready, o_out_last, o_busy, o_done;
`ifdef DECOMP_SEQ_PERF_EN
  logic [31:0]  o_stall_cycles, o_bp_cycles;
`endif

  decomp_line_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_start_comp(i_start_comp),
    .i_out_lines(i_out_lines), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_data(i_in_data), .o_dec_en(o_dec_en), .o_dec_update(o_dec_update),
    .o_dec_data(o_dec_data), .o_comp_flag(o_comp_flag), .i_dec_need(i_dec_need),
    .i_dec_valid(i_dec_valid), .i_dec_data(i_dec_data), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_busy(o_busy), .o_done(o_done)
`ifdef DECOMP_SEQ_PERF_EN
    , .o_stall_cycles(o_stall_cycles), .o_bp_cycles(o_bp_cycles)
`endif
  );

  typedef struct packed {
    logic start, comp; logic [9:0] lines; logic in_valid; logic [127:0] in_data;
    logic dec_need, dec_valid; logic [127:0] dec_data; logic out_ready;
  } in_t;
  typedef struct packed {
    logic in_ready, out_valid; logic [127:0] out_data;
    logic out_last, dec_en, comp_flag, busy, done;
  } out_t;
  typedef struct packed { logic [127:0] dat; logic last; } sb_t;
  typedef struct { in_t i; out_t e; } vec_t;

  sb_t          sb_q[$];
  int           n_cmp = 0, n_bad = 0;
  int           push_n, blk_lines, upd_cnt, en_low, done_cnt, pop_cnt;
  bit           sb_raw;
  out_t         smp;
  logic         smp_upd;
  logic [127:0] smp_ddat;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic in_t nop();
    in_t v;
    v = '0;
    v.out_ready = 1'b1;
    return v;
  endfunction

  function automatic vec_t row(input logic st, input logic cp, input logic [9:0] ln,
                               input logic iv, input logic [127:0] id,
                               input logic rdy, input logic ov, input logic [127:0] od,
                               input logic lst, input logic en, input logic cf,
                               input logic bsy, input logic dn);
    vec_t r;
    r.i = nop();
    r.i.start = st; r.i.comp = cp; r.i.lines = ln; r.i.in_valid = iv; r.i.in_data = id;
    r.e.in_ready = rdy; r.e.out_valid = ov; r.e.out_data = od; r.e.out_last = lst;
    r.e.dec_en = en; r.e.comp_flag = cf; r.e.busy = bsy; r.e.done = dn;
    return r;
  endfunction

  task automatic begin_blk(input bit raw, input int lines);
    sb_raw = raw; blk_lines = lines; push_n = 0;
    sb_q.delete();
  endtask

  task automatic sb_push(input logic [127:0] d);
    sb_t t;
    t.dat  = d;
    t.last = (push_n == blk_lines - 1);
    sb_q.push_back(t);
    push_n++;
  endtask

  // Drive one cycle's inputs at the falling edge, sample just after, advance to the next falling edge.
  task automatic cyc(input in_t v);
    sb_t e;
    i_start = v.start; i_start_comp = v.comp; i_out_lines = v.lines;
    i_in_valid = v.in_valid; i_in_data = v.in_data; i_dec_need = v.dec_need;
    i_dec_valid = v.dec_valid; i_dec_data = v.dec_data; i_out_ready = v.out_ready;
    #1;
    if (sb_raw && i_in_valid && o_in_ready) sb_push(i_in_data);
    if (!sb_raw && v.dec_valid && push_n < blk_lines) sb_push(v.dec_data);
    smp.in_ready = o_in_ready; smp.out_valid = o_out_valid; smp.out_data = o_out_data;
    smp.out_last = o_out_last; smp.dec_en = o_dec_en; smp.comp_flag = o_comp_flag;
    smp.busy = o_busy; smp.done = o_done;
    smp_upd = o_dec_update; smp_ddat = o_dec_data;
    if (o_dec_update === 1'b1) upd_cnt++;
    if (o_dec_en === 1'b0) en_low++;
    if (o_done === 1'b1) done_cnt++;
    if (o_out_valid === 1'b1 && i_out_ready) begin
      pop_cnt++;
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_empty: got line %0h, none expected", o_out_data);
      end else begin
        e = sb_q.pop_front();
        chk("sb_line", {o_out_data, o_out_last}, {e.dat, e.last});
      end
    end
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_t  v;
    vec_t tbl[11];

    begin_blk(1'b1, 0);
    i_reset = 1'b1;
    v = nop(); v.in_valid = 1'b1; v.in_data = 128'hDEAD;
    cyc(v); cyc(v);
    chk("reset_outs", smp, '0);
    chk("reset_dec", {smp_upd, smp_ddat}, '0);
    i_reset = 1'b0;

    // Raw block of 4 (start re-pulsed mid-block is ignored), then empty blocks.
    tbl[0]  = row(1, 0, 4, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = row(0, 0, 0, 1, 128'h1,  1, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = row(0, 0, 0, 1, 128'h2,  1, 1, 128'h1, 0, 0, 0, 1, 0);
    tbl[3]  = row(1, 0, 0, 1, 128'h3,  1, 1, 128'h2, 0, 0, 0, 1, 0);
    tbl[4]  = row(0, 0, 0, 1, 128'h4,  1, 1, 128'h3, 0, 0, 0, 1, 0);
    tbl[5]  = row(0, 0, 0, 0, 0,       0, 1, 128'h4, 1, 0, 0, 1, 0);
    tbl[6]  = row(0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 1);
    tbl[7]  = row(0, 0, 0, 1, 128'h5,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = row(1, 1, 0, 1, 128'h6,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = row(0, 0, 0, 1, 128'h7,  0, 0, 0, 0, 0, 0, 1, 1);
    tbl[10] = row(0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0);
    begin_blk(1'b1, 4);
    for (int k = 0; k < 11; k++) begin
      cyc(tbl[k].i);
      chk($sformatf("tbl_row%0d", k), smp, tbl[k].e);
    end
    chk("raw_sb_drained", sb_q.size(), 0);

    // Compressed block of 3 lines, two refill requests, one stray line afterwards.
    begin_blk(1'b0, 3);
    v = nop(); v.start = 1; v.comp = 1; v.lines = 3; cyc(v);
    v = nop(); v.in_valid = 1; v.in_data = 128'hA0; cyc(v);
    chk("t1_prime_update", {smp_upd, smp_ddat}, {1'b1, 128'hA0});
    chk("t1_prime_flags", {smp.dec_en, smp.comp_flag, smp.in_ready}, 3'b111);
    upd_cnt = 0; pop_cnt = 0; done_cnt = 0;
    v = nop(); v.dec_valid = 1; v.dec_data = 128'hD0; cyc(v);
    v = nop(); v.dec_need = 1; v.in_valid = 1; v.in_data = 128'hA1; v.dec_valid = 1; v.dec_data = 128'hD1; cyc(v);
    v = nop(); v.dec_need = 1; v.in_valid = 1; v.in_data = 128'hA2; v.dec_valid = 1; v.dec_data = 128'hD2; cyc(v);
    v = nop(); v.dec_valid = 1; v.dec_data = 128'hEE; cyc(v);
    chk("t1_last", {smp.out_last, smp.done}, 2'b10);
    cyc(nop());
    chk("t1_done_pulse", {smp.done, smp.busy}, 2'b11);
    cyc(nop()); cyc(nop());
    chk("t1_idle", {smp.done, smp.busy, smp.out_valid}, 3'b000);
    chk("t1_updates", upd_cnt, 2);
    chk("t1_lines", pop_cnt, 3);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_sb_drained", sb_q.size(), 0);

    // Refill starvation: need high, no input for 5 cycles.
    begin_blk(1'b0, 2);
    v = nop(); v.start = 1; v.comp = 1; v.lines = 2; cyc(v);
    v = nop(); v.in_valid = 1; v.in_data = 128'hB0; cyc(v);
    en_low = 0;
    for (int k = 0; k < 5; k++) begin
      v = nop(); v.dec_need = 1; cyc(v);
    end
    v = nop(); v.in_valid = 1; v.in_data = 128'hB1; cyc(v);
    chk("t3_resume_update", {smp_upd, smp_ddat, smp.dec_en}, {1'b1, 128'hB1, 1'b0});
    chk("t3_en_low", en_low, 5);
    v = nop(); v.dec_valid = 1; v.dec_data = 128'hC0; cyc(v);
    chk("t3_en_back", smp.dec_en, 1'b1);
    v = nop(); v.dec_valid = 1; v.dec_data = 128'hC1; cyc(v);
    cyc(nop()); cyc(nop()); cyc(nop());
    chk("t3_sb_drained", sb_q.size(), 0);
`ifdef DECOMP_SEQ_PERF_EN
    chk("t3_stall_cycles", o_stall_cycles, 5);
`endif

    // Downstream stalls for 10 cycles with one line in flight.
    begin_blk(1'b0, 4);
    v = nop(); v.start = 1; v.comp = 1; v.lines = 4; cyc(v);
    v = nop(); v.in_valid = 1; v.in_data = 128'hE0; cyc(v);
    v = nop(); v.dec_valid = 1; v.dec_data = 128'hF0; cyc(v);
    chk("t4_en_before", smp.dec_en, 1'b1);
    en_low = 0;
    v = nop(); v.out_ready = 0; v.dec_valid = 1; v.dec_data = 128'hF1; cyc(v);
    for (int k = 0; k < 9; k++) begin
      v = nop(); v.out_ready = 0; cyc(v);
    end
    chk("t4_en_low", en_low, 10);
    chk("t4_full", {smp.out_valid, smp.in_ready, smp.dec_en, smp.out_data}, {3'b100, 128'hF0});
    cyc(nop());
    v = nop(); v.dec_valid = 1; v.dec_data = 128'hF2; cyc(v);
    v = nop(); v.dec_valid = 1; v.dec_data = 128'hF3; cyc(v);
    cyc(nop());
    chk("t4_last", smp.out_last, 1'b1);
    cyc(nop());
    chk("t4_done", smp.done, 1'b1);
    cyc(nop());
    chk("t4_sb_drained", sb_q.size(), 0);
`ifdef DECOMP_SEQ_PERF_EN
    chk("t4_bp_cycles", o_bp_cycles, 10);
`endif

    // Reset in the middle of a compressed block with one line buffered.
    begin_blk(1'b0, 3);
    v = nop(); v.start = 1; v.comp = 1; v.lines = 3; cyc(v);
    v = nop(); v.in_valid = 1; v.in_data = 128'h90; cyc(v);
    v = nop(); v.out_ready = 0; v.dec_valid = 1; v.dec_data = 128'h91; cyc(v);
    v = nop(); v.out_ready = 0; cyc(v);
    chk("t6_buffered", smp.out_valid, 1'b1);
    i_reset = 1'b1;
    cyc(v);
    i_reset = 1'b0;
    begin_blk(1'b0, 0);
    done_cnt = 0;
    cyc(nop());
    chk("t6_flushed", {smp.out_valid, smp.busy, smp.in_ready}, 3'b000);
    cyc(nop()); cyc(nop());
    chk("t6_no_done", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
